// File: rtl/mem_pkg.sv
// Shared definitions for the load path: access-size encodings seen on in_size.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: picks the addressed byte/half/word out of a raw
// memory word and sign- or zero-extends it to the full word width.
module load_align
    import mem_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [OFF_W-1:0]  offset,
    output logic [DATA_W-1:0] result
);

    logic [OFF_W-1:0]  base;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] top;
    int unsigned       width;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        base  = '0;
        width = DATA_W;
        case (size_e'(size))
            SZ_BYTE: begin base = offset;                width = 8;  end
            SZ_HALF: begin base = offset & ~OFF_W'(1);   width = 16; end
            SZ_WORD: begin base = offset & ~OFF_W'(3);   width = 32; end
            default: begin base = '0;                    width = DATA_W; end
        endcase

        // A dword on a 32-bit bus falls into the default arm, i.e. a full word.
        shifted = data >> {base, 3'b000};
        mask    = {DATA_W{1'b1}} >> (DATA_W - width);
        top     = mask & ~(mask >> 1);
        result  = shifted & mask;
        if (sign_ext && (|(shifted & top))) begin
            result = result | ~mask;
        end
    end

endmodule

// File: rtl/mem_data_buffer.sv
// Load-data return buffer: aligns/extends incoming memory words and queues them
// in a first-word-fall-through FIFO with a registered output.
module mem_data_buffer
    import mem_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int OFF_W  = $clog2(DATA_W / 8),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    input  logic [OFF_W-1:0]  in_offset,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_next;
    logic [CNT_W-1:0]  remaining;
    logic [DATA_W-1:0] aligned;
    logic              push;
    logic              pop;

    load_align #(.DATA_W(DATA_W)) u_align (
        .data     (in_data),
        .size     (in_size),
        .sign_ext (in_signed),
        .offset   (in_offset),
        .result   (aligned)
    );

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Entries left after this cycle's pop, and where the head will sit next.
    assign remaining = count - CNT_W'(pop);
    assign rd_next   = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

    // NOTE: storage has no reset; pointers and count alone define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= aligned;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clock) begin
        if (rst) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            out_data <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_next;
            // Output register tracks the next head; it holds when the FIFO drains.
            if (remaining != '0) begin
                out_data <= mem[rd_next];
            end else if (push) begin
                out_data <= aligned;
            end
        end
    end

endmodule

// File: tb/tb_mem_data_buffer.sv
// Self-checking bench for mem_data_buffer: directed vectors, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_mem_data_buffer;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // 32-bit instance
    logic        rst, flush, in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [1:0]  in_size, in_offset;
    logic [2:0]  count;

    // 64-bit instance
    logic        w_rst, w_flush, w_in_valid, w_in_ready, w_in_signed, w_out_valid, w_out_ready;
    logic [63:0] w_in_data, w_out_data;
    logic [1:0]  w_in_size;
    logic [2:0]  w_in_offset;
    logic [2:0]  w_count;

    mem_data_buffer #(.DATA_W(32), .DEPTH(DEPTH)) dut32 (
        .clock(clock), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_size(in_size), .in_signed(in_signed), .in_offset(in_offset),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    mem_data_buffer #(.DATA_W(64), .DEPTH(DEPTH)) dut64 (
        .clock(clock), .rst(w_rst), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .in_size(w_in_size), .in_signed(w_in_signed), .in_offset(w_in_offset),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
        .count(w_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference extraction from the access rules: field size in bytes, aligned
    // down to its own size, then extended to the bus width.
    function automatic logic [63:0] ref_extract(input logic [63:0] data, input logic [1:0] size,
                                                input logic sgn, input int off, input int dw);
        int          nbytes;
        int          start;
        logic [63:0] v;
        logic [63:0] mask;
        nbytes = 1 << size;
        if (nbytes * 8 > dw) nbytes = dw / 8;
        start = (off / nbytes) * nbytes;
        v = data >> (start * 8);
        if (nbytes < 8) begin
            mask = (64'd1 << (nbytes * 8)) - 64'd1;
            v = v & mask;
            if (sgn && (((v >> (nbytes * 8 - 1)) & 64'd1) != 64'd0)) v = v | ~mask;
        end
        if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    // Behavioural model of the 32-bit instance
    logic [31:0] mq[$];
    logic [31:0] m_last = '0;

    task automatic cycle32();
        bit          do_push, do_pop, do_rst, do_flush;
        logic [63:0] e;
        do_rst   = rst;
        do_flush = flush;
        do_push  = in_valid && (mq.size() != DEPTH);
        do_pop   = out_ready && (mq.size() != 0);
        e = ref_extract({32'd0, in_data}, in_size, in_signed, int'(in_offset), 32);
        @(posedge clock);
        #1;
        if (do_rst) begin
            mq.delete();
            m_last = '0;
        end else if (do_flush) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(e[31:0]);
            if (mq.size() != 0) m_last = mq[0];
        end
        check("count", 64'(count), 64'(mq.size()));
        check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        check("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
        check("out_data", 64'(out_data), 64'(m_last));
    endtask

    task automatic cycle64();
        @(posedge clock);
        #1;
    endtask

    task automatic drive32(input logic v, input logic [31:0] d, input logic [1:0] sz,
                           input logic sg, input logic [1:0] off);
        in_valid  = v;
        in_data   = d;
        in_size   = sz;
        in_signed = sg;
        in_offset = off;
    endtask

    typedef struct {
        logic [31:0] data;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  off;
        logic [31:0] exp;
    } vec32_t;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  size;
        logic        sgn;
        logic [2:0]  off;
        logic [63:0] exp;
    } vec64_t;

    vec32_t v32[11];
    vec64_t v64[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        v32[0]  = '{32'h8899AABB, 2'b00, 1'b1, 2'd1, 32'hFFFFFFAA};
        v32[1]  = '{32'h8899AABB, 2'b01, 1'b0, 2'd3, 32'h00008899};
        v32[2]  = '{32'h8899AABB, 2'b01, 1'b1, 2'd3, 32'hFFFF8899};
        v32[3]  = '{32'h8899AABB, 2'b00, 1'b0, 2'd0, 32'h000000BB};
        v32[4]  = '{32'h8899AABB, 2'b00, 1'b1, 2'd2, 32'hFFFFFF99};
        v32[5]  = '{32'h8899AABB, 2'b00, 1'b1, 2'd3, 32'hFFFFFF88};
        v32[6]  = '{32'h8899AABB, 2'b01, 1'b1, 2'd0, 32'hFFFFAABB};
        v32[7]  = '{32'h8899AABB, 2'b10, 1'b1, 2'd2, 32'h8899AABB};
        v32[8]  = '{32'h8899AABB, 2'b11, 1'b0, 2'd1, 32'h8899AABB};
        v32[9]  = '{32'h12345678, 2'b00, 1'b1, 2'd3, 32'h00000012};
        v32[10] = '{32'h12345678, 2'b01, 1'b1, 2'd1, 32'h00005678};

        v64[0] = '{64'h80000000_00000001, 2'b10, 1'b1, 3'd4, 64'hFFFFFFFF_80000000};
        v64[1] = '{64'h80000000_00000001, 2'b11, 1'b1, 3'd5, 64'h80000000_00000001};
        v64[2] = '{64'h80000000_00000001, 2'b00, 1'b1, 3'd7, 64'hFFFFFFFF_FFFFFF80};
        v64[3] = '{64'h80000000_00000001, 2'b01, 1'b0, 3'd6, 64'h00000000_00008000};
        v64[4] = '{64'h80000000_00000001, 2'b10, 1'b1, 3'd0, 64'h00000000_00000001};

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive32(1'b0, 32'h0, 2'b00, 1'b0, 2'd0);
        w_rst = 1'b1; w_flush = 1'b0; w_out_ready = 1'b0; w_in_valid = 1'b0;
        w_in_data = '0; w_in_size = 2'b00; w_in_signed = 1'b0; w_in_offset = '0;

        // Reset state
        cycle32();
        cycle32();
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        w_rst = 1'b0;

        // Table vectors: push one, see it next cycle, drain
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive32(1'b1, v32[i].data, v32[i].size, v32[i].sgn, v32[i].off);
            cycle32();
            check($sformatf("vec%0d_data", i), 64'(out_data), 64'(v32[i].exp));
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            in_valid = 1'b0;
            cycle32();
            check($sformatf("vec%0d_drain", i), 64'(count), 64'd0);
            check($sformatf("vec%0d_hold", i), 64'(out_data), 64'(v32[i].exp));
        end

        // Fill to full, then pop while offering a fifth value
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive32(1'b1, 32'(i), 2'b10, 1'b0, 2'd0);
            cycle32();
        end
        check("full_count", 64'(count), 64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_head", 64'(out_data), 64'd1);
        drive32(1'b1, 32'd5, 2'b10, 1'b0, 2'd0);
        out_ready = 1'b1;
        cycle32();
        check("full_pop_count", 64'(count), 64'd3);
        check("full_pop_head", 64'(out_data), 64'd2);
        in_valid = 1'b0;
        for (int i = 3; i <= 4; i++) begin
            cycle32();
            check($sformatf("full_order%0d", i), 64'(out_data), 64'(i));
        end
        cycle32();
        check("full_empty", 64'(out_valid), 64'd0);
        check("full_no_fifth", 64'(out_data), 64'd4);

        // Streaming push+pop across pointer wrap
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive32(1'b1, 32'(100 + i), 2'b10, 1'b0, 2'd0);
            cycle32();
            check($sformatf("stream%0d_count", i), 64'(count), 64'd1);
            check($sformatf("stream%0d_data", i), 64'(out_data), 64'(100 + i));
        end
        in_valid = 1'b0;
        cycle32();

        // Flush with a concurrent push
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive32(1'b1, 32'(200 + i), 2'b10, 1'b0, 2'd0);
            cycle32();
        end
        check("pre_flush_count", 64'(count), 64'd3);
        drive32(1'b1, 32'hDEADBEEF, 2'b10, 1'b0, 2'd0);
        flush = 1'b1;
        cycle32();
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        cycle32();
        check("flush_not_stored", 64'(count), 64'd0);
        drive32(1'b1, 32'h77, 2'b10, 1'b0, 2'd0);
        cycle32();
        check("post_flush_head", 64'(out_data), 64'h77);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle32();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 50);
            flush     = ($urandom_range(0, 99) < 3);
            rst       = ($urandom_range(0, 199) < 1);
            in_data   = $urandom;
            in_size   = 2'($urandom_range(0, 3));
            in_signed = 1'($urandom_range(0, 1));
            in_offset = 2'($urandom_range(0, 3));
            cycle32();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cycle32();

        // 64-bit instance: extraction vectors
        w_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w_in_valid  = 1'b1;
            w_in_data   = v64[i].data;
            w_in_size   = v64[i].size;
            w_in_signed = v64[i].sgn;
            w_in_offset = v64[i].off;
            cycle64();
            check($sformatf("w_vec%0d_data", i), w_out_data, v64[i].exp);
            check($sformatf("w_vec%0d_valid", i), 64'(w_out_valid), 64'd1);
            w_in_valid = 1'b0;
            cycle64();
            check($sformatf("w_vec%0d_drain", i), 64'(w_count), 64'd0);
        end

        // 64-bit instance: reset mid-stream
        w_out_ready = 1'b0;
        w_in_valid  = 1'b1;
        w_in_size   = 2'b11;
        w_in_data   = 64'h1111_2222_3333_4444;
        cycle64();
        w_in_data   = 64'h5555_6666_7777_8888;
        cycle64();
        check("w_pre_rst_count", 64'(w_count), 64'd2);
        check("w_pre_rst_head", w_out_data, 64'h1111_2222_3333_4444);
        w_rst = 1'b1;
        cycle64();
        check("w_rst_count", 64'(w_count), 64'd0);
        check("w_rst_valid", 64'(w_out_valid), 64'd0);
        check("w_rst_data", w_out_data, 64'd0);
        check("w_rst_ready", 64'(w_in_ready), 64'd1);
        w_rst = 1'b0;
        w_in_valid = 1'b0;
        cycle64();
        check("w_post_rst_count", 64'(w_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_data_buffer.md
MEM_DATA_BUFFER -- requirements
Module: mem_data_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, memory word width; legal values are 32 or 64.
REQ-002 The block SHALL have parameter DEPTH, default 4, buffer entries; it is a power of two and at least 2.
REQ-003 The block SHALL have localparam OFF_W = log2(DATA_W/8), the byte-offset width, and CNT_W = log2(DEPTH)+1.
REQ-004 The block SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous discard of all entries.
REQ-007 The block SHALL have port in_valid, input, 1 bit: load data offered.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the buffer accepts data this cycle.
REQ-009 The block SHALL have port in_data, input, DATA_W bits: raw memory word.
REQ-010 The block SHALL have port in_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 dword.
REQ-011 The block SHALL have port in_signed, input, 1 bit: 1 means sign-extend, 0 means zero-extend.
REQ-012 The block SHALL have port in_offset, input, OFF_W bits: byte address of the access within the word.
REQ-013 The block SHALL have port out_valid, output, 1 bit: the head entry is present.
REQ-014 The block SHALL have port out_ready, input, 1 bit: the consumer takes the head.
REQ-015 The block SHALL have port out_data, output, DATA_W bits: the extracted, extended head value.
REQ-016 The block SHALL have port count, output, CNT_W bits: the number of occupied entries.

Function
REQ-017 A push SHALL occur when in_valid and in_ready are both 1 on a clock edge.
REQ-018 A pop SHALL occur when out_valid and out_ready are both 1 on a clock edge.
REQ-019 in_ready SHALL equal (count != DEPTH); there is no pass-through when full, even if a pop occurs in the same cycle.
REQ-020 Extraction SHALL occur before storage:
- byte: in_data[8*off +: 8];
- half: in_data[16*(off>>1) +: 16], with offset bit 0 ignored;
- word: in_data[32*(off>>2) +: 32] when DATA_W=64, otherwise the whole word.
REQ-021 in_size 11 SHALL select the full 64-bit word when DATA_W=64, and SHALL be treated as word when DATA_W=32.
REQ-022 The extracted field SHALL be extended to DATA_W: sign-extended from its MSB when in_signed=1, zero-extended otherwise.
REQ-023 The buffer SHALL be FIFO with first-word-fall-through: data pushed at edge N SHALL appear on out_data, with out_valid=1, after edge N (1-cycle latency).
REQ-024 out_data SHALL be driven from storage or registers, with no combinational path from in_* to out_*.
REQ-025 A simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-026 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-027 When empty, out_valid SHALL be 0 and out_data SHALL hold its last value; a pop SHALL NOT be possible when empty.
REQ-028 flush=1 SHALL at the next edge set count=0, out_valid=0, and both pointers to 0; any push or pop in that cycle SHALL be discarded.
REQ-029 rst SHALL have priority over flush, and flush SHALL have priority over push and pop.

Reset
REQ-030 On rst=1 at a clock edge: count=0, out_valid=0, out_data=0, pointers=0, in_ready=1 from the following cycle.
REQ-031 Reset mid-stream SHALL discard all entries; storage contents need not be cleared.

Structure
REQ-032 The size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD) SHALL be placed in shared package mem_pkg.
REQ-033 Extraction and extension SHALL be a combinational sub-module load_align, instantiated once on the input side.
REQ-034 The FIFO, pointers and count SHALL reside in mem_data_buffer.

Verification
REQ-035 The bench SHALL apply in_data=0x8899AABB, size=byte, signed=1, offset=1, with out_ready=1 -> out_data=0xFFFFFFAA one cycle later, with count returning to 0.
REQ-036 The bench SHALL apply 0x8899AABB, size=half, signed=0, offset=3 -> out_data=0x00008899; with signed=1 -> out_data=0xFFFF8899.
REQ-037 The bench SHALL push word values 1,2,3,4 with out_ready=0 -> count=4 and in_ready=0; then push with out_ready=1 -> 1,2,3,4 popped in order, with no fifth push accepted while full.
REQ-038 The bench SHALL run continuous push and pop with DEPTH=4 for 10 values -> count stays at 1, values are in order, and pointer wrap is exercised.
REQ-039 The bench SHALL fill 3 entries and then assert flush together with in_valid -> count=0, out_valid=0, and the flushed-cycle data is not stored.
REQ-040 The bench SHALL set DATA_W=64, in_data=0x80000000_00000001, size=word, signed=1, offset=4 -> out_data=0xFFFFFFFF_80000000; and assert rst mid-stream -> all outputs at reset values.
